// File: rtl/mux3_arbiter_if.sv
// mux3_arbiter_if
//   Bundles the requester/datapath-facing signals of the MUX3 round-robin
//   arbiter.
//   REQ  [2:0]  request, REQ[0]=A, REQ[1]=B, REQ[2]=C
//   GNT  [2:0]  registered one-hot grant, same bit order as REQ, 000 = none
//   S    [1:0]  registered MUX3 select, 00=A 01=B 10=C
//   BUSY        registered, high while any grant is active
//   Modports:
//     master : requester side (drives REQ, observes GNT/S/BUSY)
//     slave  : arbiter side (observes REQ, drives GNT/S/BUSY)
interface mux3_arbiter_if;
  logic [2:0] REQ;
  logic [2:0] GNT;
  logic [1:0] S;
  logic       BUSY;

  modport master (output REQ, input GNT, input S, input BUSY);
  modport slave  (input REQ, output GNT, output S, output BUSY);
endinterface

// File: rtl/mux3_arbiter.sv
// mux3_arbiter
//   Round-robin arbiter sharing one MUX3 datapath among three requesters
//   (A, B, C). Drives the MUX3 select directly and returns a one-hot grant.
//   An owner may hold the datapath for at most HOLD_MAX consecutive cycles
//   while another requester is waiting; alone, it may keep it indefinitely.
//   Ports:
//     clk    clock, all state updates on the rising edge
//     reset  asynchronous, active-low reset
//     bus    mux3_arbiter_if.slave (REQ in; GNT, S, BUSY out, all registered)
//   Parameters:
//     HOLD_MAX  max consecutive grant cycles per owner while others request (>=1)
module mux3_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  mux3_arbiter_if.slave bus
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_MAX);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      gnt_q, gnt_d;
  logic [1:0]      s_q, s_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Last owner; while in GRANT this is also the current owner.
  logic [1:0]      last_q, last_d;

  logic [2:0]      others;
  logic [2:0]      pick_src;
  logic [2:0]      pick;
  logic            do_take;

  // First requester in round-robin order starting after index 'after'.
  // Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                         input logic [1:0] after);
    logic [2:0] r;
    r = 3'b000;
    // Walk the order backwards so the nearest candidate overwrites the rest.
    for (int k = 3; k >= 1; k--) begin
      int i;
      i = (int'(after) + k) % 3;
      if (req[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      s_q     <= 2'b00;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 2'd2;   // C, so A has first priority out of reset
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    s_d      = s_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    do_take  = 1'b0;
    pick_src = 3'b000;
    pick     = 3'b000;
    others   = bus.REQ & ~onehot(last_q);

    case (state_q)
      IDLE: begin
        if (|bus.REQ) begin
          do_take  = 1'b1;
          pick_src = bus.REQ;
        end
      end
      GRANT: begin
        if (bus.REQ[last_q]) begin
          if (cnt_q < HOLD_CNT) begin
            cnt_d = cnt_q + CW'(1);
          end else if (|others) begin
            // Hold limit reached with someone waiting: rotate.
            do_take  = 1'b1;
            pick_src = others;
          end
          // Alone at the limit: keep the grant, count stays saturated.
        end else if (|others) begin
          // Owner dropped: hand off on the same edge, no idle gap.
          do_take  = 1'b1;
          pick_src = others;
        end else begin
          state_d = IDLE;
          gnt_d   = 3'b000;
          busy_d  = 1'b0;
          cnt_d   = '0;
          // S keeps pointing at the previous owner.
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_take) begin
      pick    = rr_pick(pick_src, last_q);
      state_d = GRANT;
      gnt_d   = onehot(pick[1:0]);
      s_d     = pick[1:0];
      busy_d  = 1'b1;
      cnt_d   = CW'(1);
      last_d  = pick[1:0];
    end
  end

  assign bus.GNT  = gnt_q;
  assign bus.S    = s_q;
  assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_mux3_arbiter.sv
// tb_mux3_arbiter
//   Directed and randomized bench for mux3_arbiter (HOLD_MAX=4). Expected
//   values come from explicit constants for the directed scenarios and from
//   a rule-level reference model (owner/last/count integers) for random runs.
module tb_mux3_arbiter;

  localparam int H = 4;

  logic clk;
  logic reset;

  mux3_arbiter_if bus ();

  mux3_arbiter #(.HOLD_MAX(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: owner = -1 means nobody holds the datapath.
  int         m_owner;
  int         m_last;
  int         m_count;
  int         m_s;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_next(input logic [2:0] cand, input int after);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (after + k) % 3;
      if (cand[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 2;
    m_count = 0;
    m_s     = 0;
  endtask

  task automatic model_give(input int w);
    m_owner = w;
    m_last  = w;
    m_count = 1;
    m_s     = w;
  endtask

  // Apply one clock edge worth of arbitration rules to the model.
  task automatic model_step(input logic [2:0] req);
    logic [2:0] others;
    if (m_owner < 0) begin
      if (req != 3'b000) model_give(rr_next(req, m_last));
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      if (req[m_owner]) begin
        if (m_count < H) m_count++;
        else if (others != 3'b000) model_give(rr_next(others, m_owner));
      end else if (others != 3'b000) begin
        model_give(rr_next(others, m_owner));
      end else begin
        m_owner = -1;
        m_count = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] eg;
    eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    check({tag, "_gnt"}, {29'd0, bus.GNT}, eg);
    check({tag, "_s"}, {30'd0, bus.S}, 32'(m_s));
    check({tag, "_busy"}, {31'd0, bus.BUSY}, {31'd0, (m_owner >= 0)});
    check({tag, "_onehot0"}, {31'd0, $onehot0(bus.GNT)}, 32'd1);
  endtask

  task automatic check_out(input string tag, input logic [2:0] g,
                           input logic [1:0] s, input logic b);
    check({tag, "_gnt"}, {29'd0, bus.GNT}, {29'd0, g});
    check({tag, "_s"}, {30'd0, bus.S}, {30'd0, s});
    check({tag, "_busy"}, {31'd0, bus.BUSY}, {31'd0, b});
  endtask

  // Drive REQ on the falling edge, let one rising edge pass, sample 1 later.
  task automatic step(input logic [2:0] req);
    @(negedge clk);
    bus.REQ = req;
    @(posedge clk);
    model_step(req);
    #1;
  endtask

  // Assert reset asynchronously away from any edge, check, then release.
  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_out(tag, 3'b000, 2'b00, 1'b0);
    @(negedge clk);
    bus.REQ = 3'b000;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rq;
    int         ei;

    // 1: reset with REQ=111, outputs clear before any clock edge
    reset   = 1'b1;
    bus.REQ = 3'b111;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_out("rst_async", 3'b000, 2'b00, 1'b0);
    @(negedge clk);
    bus.REQ = 3'b000;
    reset = 1'b1;

    // 2: single request from A, then release
    step(3'b001);
    check_out("a_grant", 3'b001, 2'b00, 1'b1);
    step(3'b000);
    check_out("a_release", 3'b000, 2'b00, 1'b0);

    // 3: all request, HOLD_MAX rotation A x4, B x4, C x4, A
    pulse_reset("rst_t3");
    for (int i = 0; i < 13; i++) begin
      step(3'b111);
      ei = (i / H) % 3;
      check_out($sformatf("rr_%0d", i), 3'(1 << ei), 2'(ei), 1'b1);
    end

    // 4: A owner, A drops while B requests -> B on the same edge
    pulse_reset("rst_t4");
    step(3'b011);
    check_out("t4_a", 3'b001, 2'b00, 1'b1);
    step(3'b010);
    check_out("t4_handoff", 3'b010, 2'b01, 1'b1);

    // 5: C alone for 10 cycles, grant never drops
    pulse_reset("rst_t5");
    for (int i = 0; i < 10; i++) begin
      step(3'b100);
      check_out($sformatf("c_sat_%0d", i), 3'b100, 2'b10, 1'b1);
    end
    step(3'b000);
    check_out("c_drop", 3'b000, 2'b10, 1'b0);

    // 6: B owner, reset mid-cycle, then REQ=111 gives A
    pulse_reset("rst_t6a");
    step(3'b010);
    check_out("t6_b", 3'b010, 2'b01, 1'b1);
    #2;
    pulse_reset("t6_midrst");
    step(3'b111);
    check_out("t6_after", 3'b001, 2'b00, 1'b1);

    // Randomized traffic against the reference model
    pulse_reset("rst_rand");
    rq = 3'b000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) rq = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 9) < 2) rq[$urandom_range(0, 2)] ^= 1'b1;
      step(rq);
      check_model($sformatf("rnd_%0d", i));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
